// File: rtl/channel_buffer.sv
// MCU channel buffer: gathers four Y blocks plus Cb/Cr quads of one 4:2:0 MCU and
// drains them as four aligned (Y, Cb, Cr) block triples, one per cycle.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no drain in progress, outputs zero, input bank accepting writes
// ST_DRAIN | presenting output-bank triple drain_idx, valid_out high
module channel_buffer #(
    parameter int Q  = 16,
    parameter int CH = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic signed [3:0][7:0][7:0][Q-1:0]    blocks_in,
    input  logic                                  wr_en,
    input  logic        [$clog2(CH+1)-1:0]        ch,
    output logic signed [7:0][7:0][Q-1:0]         y_out,
    output logic signed [7:0][7:0][Q-1:0]         cb_out,
    output logic signed [7:0][7:0][Q-1:0]         cr_out,
    output logic                                  valid_out
);

    localparam int CW = $clog2(CH + 1);

    typedef logic [7:0][7:0][Q-1:0] blk_t;
    typedef enum logic {ST_IDLE, ST_DRAIN} state_t;

    blk_t   y_slot [4];
    blk_t   cb_slot[4];
    blk_t   ob_y   [4];
    blk_t   ob_cb  [4];
    blk_t   ob_cr  [4];
    logic [1:0] y_ptr;
    logic [1:0] drain_idx;
    state_t state;
    state_t state_nxt;

    logic y_wr;
    logic cb_wr;
    logic cr_wr;

    assign y_wr  = wr_en && (ch == CW'(0));
    assign cb_wr = wr_en && (ch == CW'(1));
    assign cr_wr = wr_en && (ch == CW'(2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Cr write snapshots the whole MCU into the output bank, so later Y/Cb
    // writes can refill the input bank while the drain is still running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                y_slot[i]  <= '0;
                cb_slot[i] <= '0;
                ob_y[i]    <= '0;
                ob_cb[i]   <= '0;
                ob_cr[i]   <= '0;
            end
            y_ptr     <= '0;
            drain_idx <= '0;
        end else begin
            if (y_wr) begin
                y_slot[y_ptr] <= blocks_in[0];
                y_ptr         <= y_ptr + 2'd1;
            end
            if (cb_wr) begin
                for (int i = 0; i < 4; i++) begin
                    cb_slot[i] <= blocks_in[i];
                end
            end
            if (cr_wr) begin
                for (int i = 0; i < 4; i++) begin
                    ob_y[i]  <= y_slot[i];
                    ob_cb[i] <= cb_slot[i];
                    ob_cr[i] <= blocks_in[i];
                end
                drain_idx <= '0;
                y_ptr     <= '0;
            end else if (state == ST_DRAIN) begin
                drain_idx <= drain_idx + 2'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        valid_out = 1'b0;
        y_out     = '0;
        cb_out    = '0;
        cr_out    = '0;
        if (state == ST_DRAIN) begin
            valid_out = 1'b1;
            y_out     = ob_y[drain_idx];
            cb_out    = ob_cb[drain_idx];
            cr_out    = ob_cr[drain_idx];
            if (drain_idx == 2'd3) begin
                state_nxt = ST_IDLE;
            end
        end
        if (cr_wr) begin
            state_nxt = ST_DRAIN;
        end
    end

endmodule

// File: tb/tb_channel_buffer.sv
// Directed bench for channel_buffer: reset, basic MCU, overwrite, ignored channel,
// overlapping drains, drain restart and negative samples.
module tb_channel_buffer;

    localparam int Q  = 16;
    localparam int CH = 3;

    typedef logic signed [7:0][7:0][Q-1:0]      blk_t;
    typedef logic signed [3:0][7:0][7:0][Q-1:0] quad_t;

    logic        clk;
    logic        rst;
    quad_t       blocks_in;
    logic        wr_en;
    logic [1:0]  ch;
    blk_t        y_out;
    blk_t        cb_out;
    blk_t        cr_out;
    logic        valid_out;

    int errors = 0;
    int checks = 0;

    channel_buffer #(.Q(Q), .CH(CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .blocks_in (blocks_in),
        .wr_en     (wr_en),
        .ch        (ch),
        .y_out     (y_out),
        .cb_out    (cb_out),
        .cr_out    (cr_out),
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ramp=1: sample(r,c) = r+c+base; ramp=0: every sample = base
    function automatic blk_t mk(input int base, input bit ramp);
        blk_t b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[r][c] = Q'(ramp ? (r + c + base) : base);
        return b;
    endfunction

    // One-cycle write: inputs set on a falling edge, sampled on the next rising
    // edge, cleared on the following falling edge (where triple 0 is then visible).
    task automatic do_write(input logic [1:0] wch, input quad_t q);
        @(negedge clk);
        wr_en     = 1'b1;
        ch        = wch;
        blocks_in = q;
        @(negedge clk);
        wr_en     = 1'b0;
        blocks_in = '0;
    endtask

    task automatic write_y(input int base, input bit ramp);
        quad_t q;
        q[0] = mk(base, ramp);
        q[1] = mk(111, 1'b0);
        q[2] = mk(222, 1'b0);
        q[3] = mk(333, 1'b0);
        do_write(2'd0, q);
    endtask

    task automatic write_quad(input logic [1:0] wch, input int base, input int step, input bit ramp);
        quad_t q;
        for (int k = 0; k < 4; k++) q[k] = mk(base + step * k, ramp);
        do_write(wch, q);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", valid_out);
        end
        checks++;
        if (y_out !== '0 || cb_out !== '0 || cr_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: y00=%0d cb00=%0d cr00=%0d want 0",
                     $signed(y_out[0][0]), $signed(cb_out[0][0]), $signed(cr_out[0][0]));
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 4; i++) begin
            write_y(i, 1'b1);
            repeat (3) @(negedge clk);
        end
        write_quad(2'd1, 5, 10, 1'b1);
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_cb_no_valid: got %b want 0", valid_out);
        end
        write_quad(2'd2, 6, 20, 1'b1);
        checks++;
        if (y_out[7][7] !== Q'(15)) begin
            errors++;
            $display("FAIL basic_y77: got %0d want 15", $signed(y_out[7][7]));
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (valid_out !== 1'b1 || y_out !== mk(1 + k, 1'b1) || cb_out !== mk(5 + 10 * k, 1'b1)
                || cr_out !== mk(6 + 20 * k, 1'b1)) begin
                errors++;
                $display("FAIL basic_triple%0d: v=%b y00=%0d cb00=%0d cr00=%0d want 1 %0d %0d %0d", k,
                         valid_out, $signed(y_out[0][0]), $signed(cb_out[0][0]), $signed(cr_out[0][0]),
                         1 + k, 5 + 10 * k, 6 + 20 * k);
            end
            @(negedge clk);
        end
        checks++;
        if (valid_out !== 1'b0 || y_out !== '0) begin
            errors++;
            $display("FAIL basic_drain_end: v=%b y00=%0d want 0 0", valid_out, $signed(y_out[0][0]));
        end
    endtask

    task automatic test_reset_mid_drain();
        write_quad(2'd2, 9, 1, 1'b0);
        checks++;
        if (valid_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_drain_started: got %b want 1", valid_out);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || cr_out !== '0) begin
            errors++;
            $display("FAIL mid_drain_reset: v=%b cr00=%0d want 0 0", valid_out, $signed(cr_out[0][0]));
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_drain_stays_off: got %b want 0", valid_out);
        end
    endtask

    task automatic test_overwrite();
        for (int i = 1; i <= 5; i++) write_y(i, 1'b0);
        write_quad(2'd1, 50, 1, 1'b0);
        write_quad(2'd2, 60, 1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            int ey;
            ey = (k == 0) ? 5 : k + 1;
            checks++;
            if (valid_out !== 1'b1 || y_out !== mk(ey, 1'b0) || cb_out !== mk(50 + k, 1'b0)) begin
                errors++;
                $display("FAIL overwrite_triple%0d: v=%b y=%0d cb=%0d want 1 %0d %0d", k, valid_out,
                         $signed(y_out[0][0]), $signed(cb_out[0][0]), ey, 50 + k);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignored_channel();
        quad_t q;
        for (int k = 0; k < 4; k++) q[k] = mk(99, 1'b0);
        do_write(2'd3, q);
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL ignored_no_valid: got %b want 0", valid_out);
        end
        write_quad(2'd2, 7, 0, 1'b0);
        checks++;
        if (y_out !== mk(5, 1'b0) || cb_out !== mk(50, 1'b0) || cr_out !== mk(7, 1'b0)) begin
            errors++;
            $display("FAIL ignored_state: y=%0d cb=%0d cr=%0d want 5 50 7",
                     $signed(y_out[0][0]), $signed(cb_out[0][0]), $signed(cr_out[0][0]));
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) write_y(10 + i, 1'b0);
        write_quad(2'd1, 20, 1, 1'b0);
        write_quad(2'd2, 30, 1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (valid_out !== 1'b1 || y_out !== mk(10 + k, 1'b0) || cb_out !== mk(20 + k, 1'b0)
                || cr_out !== mk(30 + k, 1'b0)) begin
                errors++;
                $display("FAIL overlap_first%0d: v=%b y=%0d cb=%0d cr=%0d want 1 %0d %0d %0d", k, valid_out,
                         $signed(y_out[0][0]), $signed(cb_out[0][0]), $signed(cr_out[0][0]), 10 + k, 20 + k, 30 + k);
            end
            wr_en     = 1'b1;
            ch        = 2'd0;
            blocks_in = '0;
            blocks_in[0] = mk(40 + k, 1'b0);
            @(negedge clk);
        end
        wr_en = 1'b0;
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL overlap_gap: got %b want 0", valid_out);
        end
        write_quad(2'd1, 44, 1, 1'b0);
        write_quad(2'd2, 48, 1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (valid_out !== 1'b1 || y_out !== mk(40 + k, 1'b0) || cb_out !== mk(44 + k, 1'b0)
                || cr_out !== mk(48 + k, 1'b0)) begin
                errors++;
                $display("FAIL overlap_second%0d: v=%b y=%0d cb=%0d cr=%0d want 1 %0d %0d %0d", k, valid_out,
                         $signed(y_out[0][0]), $signed(cb_out[0][0]), $signed(cr_out[0][0]), 40 + k, 44 + k, 48 + k);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_restart();
        write_quad(2'd2, 70, 1, 1'b0);
        @(negedge clk);
        checks++;
        if (cr_out !== mk(71, 1'b0)) begin
            errors++;
            $display("FAIL restart_k1: cr=%0d want 71", $signed(cr_out[0][0]));
        end
        write_quad(2'd2, 80, 1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (valid_out !== 1'b1 || cr_out !== mk(80 + k, 1'b0)) begin
                errors++;
                $display("FAIL restart_triple%0d: v=%b cr=%0d want 1 %0d", k, valid_out,
                         $signed(cr_out[0][0]), 80 + k);
            end
            @(negedge clk);
        end
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL restart_end: got %b want 0", valid_out);
        end
    endtask

    task automatic test_negative();
        for (int i = 0; i < 4; i++) write_y(-2048, 1'b0);
        write_quad(2'd1, -2048, 0, 1'b0);
        write_quad(2'd2, -2048, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (valid_out !== 1'b1 || y_out !== mk(-2048, 1'b0) || cb_out !== mk(-2048, 1'b0)
                || cr_out !== mk(-2048, 1'b0)) begin
                errors++;
                $display("FAIL negative_triple%0d: v=%b y=%0d cb=%0d cr=%0d want -2048", k, valid_out,
                         $signed(y_out[3][5]), $signed(cb_out[3][5]), $signed(cr_out[3][5]));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst       = 1'b0;
        wr_en     = 1'b0;
        ch        = 2'd0;
        blocks_in = '0;
        test_reset();
        test_basic();
        test_reset_mid_drain();
        test_overwrite();
        test_ignored_channel();
        test_back_to_back();
        test_restart();
        test_negative();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
